cacheline_adapter: RTL and testbench

Memory-side responder for the cache downward-facing port (dfp). It accepts 256-bit line read/write requests from an icache/dcache and converts each into a burst of 64-bit beats on the banked burst-memory (bmem) interface. Read beats are reassembled into a full line and returned with a single-cycle dfp_resp. One adapter sits between each cache (or the arbiter) and bmem.

---
 rtl/cacheline_adapter.sv | 191 +++++++++++++++++++
 tb/tb_cacheline_adapter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adapter.sv
// Cache dfp line responder: turns each 256-bit line read/write into a bmem burst of BEATS beats.
// Optional CACHELINE_ADAPTER_PERF_EN adds rd_lines/wr_lines/stall_cycles counters.
module cacheline_adapter #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             dfp_addr,
    input  logic                    dfp_read,
    input  logic                    dfp_write,
    input  logic [BEATS*BEAT_W-1:0] dfp_wdata,
    output logic [BEATS*BEAT_W-1:0] dfp_rdata,
    output logic                    dfp_resp,
    output logic [31:0]             bmem_addr,
    output logic                    bmem_read,
    output logic                    bmem_write,
    output logic [BEAT_W-1:0]       bmem_wdata,
    input  logic                    bmem_ready,
    input  logic [31:0]             bmem_raddr,
    input  logic [BEAT_W-1:0]       bmem_rdata,
    input  logic                    bmem_rvalid
);

    localparam int LINE_W = BEATS * BEAT_W;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_WAIT  = 3'd2,
        WR_BURST = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [31:0]         addr_r, addr_s;
    logic [LINE_W-1:0]   wline_r, wline_s;
    logic [LINE_W-1:0]   rline_r, rline_s;
    logic [LINE_W-1:0]   rdata_s;
    logic                resp_s;
    logic                bmem_read_s;
    logic                bmem_write_s;
    logic [31:0]         bmem_addr_s;
    logic [BEAT_W-1:0]   bmem_wdata_s;

    // Next-state, datapath and next-output decode; outputs are registered from the next state
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        addr_s  = addr_r;
        wline_s = wline_r;
        rline_s = rline_r;
        rdata_s = dfp_rdata;
        case (state_r)
            IDLE: begin
                if (dfp_write) begin
                    addr_s  = dfp_addr & LINE_MASK;
                    wline_s = dfp_wdata;
                    cnt_s   = '0;
                    state_s = WR_BURST;
                end else if (dfp_read) begin
                    addr_s  = dfp_addr & LINE_MASK;
                    state_s = RD_REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_REQ: begin
                if (bmem_ready) begin
                    cnt_s   = '0;
                    state_s = RD_WAIT;
                end else begin
                    state_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                // Beats tagged with another base address belong to someone else
                if (bmem_rvalid && (bmem_raddr == addr_r)) begin
                    rline_s[int'(cnt_r)*BEAT_W +: BEAT_W] = bmem_rdata;
                    if (cnt_r == LAST_BEAT) begin
                        rdata_s = rline_s;
                        state_s = RESP;
                    end else begin
                        cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_s = RD_WAIT;
                end
            end
            WR_BURST: begin
                if (bmem_ready) begin
                    if (cnt_r == LAST_BEAT) begin
                        state_s = RESP;
                    end else begin
                        cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_s = WR_BURST;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        resp_s       = (state_s == RESP);
        bmem_read_s  = (state_s == RD_REQ);
        bmem_write_s = (state_s == WR_BURST);
        bmem_addr_s  = addr_s;
        if (state_s == WR_BURST) begin
            bmem_wdata_s = wline_s[int'(cnt_s)*BEAT_W +: BEAT_W];
        end else begin
            bmem_wdata_s = '0;
        end
    end

    // State, latched request and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            addr_r     <= 32'h0000_0000;
            wline_r    <= '0;
            rline_r    <= '0;
            dfp_rdata  <= '0;
            dfp_resp   <= 1'b0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_addr  <= 32'h0000_0000;
            bmem_wdata <= '0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            addr_r     <= addr_s;
            wline_r    <= wline_s;
            rline_r    <= rline_s;
            dfp_rdata  <= rdata_s;
            dfp_resp   <= resp_s;
            bmem_read  <= bmem_read_s;
            bmem_write <= bmem_write_s;
            bmem_addr  <= bmem_addr_s;
            bmem_wdata <= bmem_wdata_s;
        end
    end

`ifdef CACHELINE_ADAPTER_PERF_EN
    logic [63:0] rd_lines;
    logic [63:0] wr_lines;
    logic [63:0] stall_cycles;
    logic        op_write_r;

    // Performance counters; op_write_r freezes once the request leaves IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_lines     <= 64'd0;
            wr_lines     <= 64'd0;
            stall_cycles <= 64'd0;
            op_write_r   <= 1'b0;
        end else begin
            if (state_r == IDLE) begin
                op_write_r <= dfp_write;
            end else begin
                op_write_r <= op_write_r;
            end
            if (state_r == RESP) begin
                if (op_write_r) begin
                    wr_lines <= wr_lines + 64'd1;
                end else begin
                    rd_lines <= rd_lines + 64'd1;
                end
            end else begin
                rd_lines <= rd_lines;
                wr_lines <= wr_lines;
            end
            if (((state_r == RD_REQ) || (state_r == WR_BURST)) && !bmem_ready) begin
                stall_cycles <= stall_cycles + 64'd1;
            end else begin
                stall_cycles <= stall_cycles;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed self-checking bench for cacheline_adapter: reads, stalled writes, stale beats, reset, ordering.
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int vectors = 0;
    int errors  = 0;
    logic [255:0] last_line;

    cacheline_adapter #(.BEATS(4), .BEAT_W(64)) dut (
        .clk(clk), .rst(rst),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
        .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; dfp_addr = 32'h0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
        bmem_ready = 1'b0; bmem_raddr = 32'h0; bmem_rdata = 64'h0; bmem_rvalid = 1'b0;
        tick; tick;
        vectors++; if (dfp_resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b want 0", dfp_resp); end
        vectors++; if (dfp_rdata !== 256'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", dfp_rdata); end
        vectors++; if (bmem_read !== 1'b0) begin errors++; $display("FAIL reset_bmem_read: got %b want 0", bmem_read); end
        vectors++; if (bmem_write !== 1'b0) begin errors++; $display("FAIL reset_bmem_write: got %b want 0", bmem_write); end
        vectors++; if (bmem_addr !== 32'h0) begin errors++; $display("FAIL reset_bmem_addr: got %h want 0", bmem_addr); end
        vectors++; if (bmem_wdata !== 64'h0) begin errors++; $display("FAIL reset_bmem_wdata: got %h want 0", bmem_wdata); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_read_basic;
        int early = 0;
        logic [255:0] exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        dfp_addr = 32'h0000_1234; dfp_read = 1'b1;
        tick;
        vectors++; if (bmem_read !== 1'b1) begin errors++; $display("FAIL rd_req: bmem_read got %b want 1", bmem_read); end
        vectors++; if (bmem_addr !== 32'h0000_1220) begin errors++; $display("FAIL rd_addr: got %h want 00001220", bmem_addr); end
        bmem_ready = 1'b1;
        tick;
        bmem_ready = 1'b0;
        vectors++; if (bmem_read !== 1'b0) begin errors++; $display("FAIL rd_req_drop: bmem_read got %b want 0", bmem_read); end
        for (int i = 0; i < 4; i++) begin
            bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_1220;
            bmem_rdata = 64'h1111_1111_1111_1111 * 64'(i + 1);
            tick;
            if (i < 3 && dfp_resp) early++;
        end
        bmem_rvalid = 1'b0;
        vectors++; if (early !== 0) begin errors++; $display("FAIL rd_early_resp: got %0d want 0", early); end
        vectors++; if (dfp_resp !== 1'b1) begin errors++; $display("FAIL rd_resp: got %b want 1", dfp_resp); end
        vectors++; if (dfp_rdata !== exp_line) begin errors++; $display("FAIL rd_line: got %h want %h", dfp_rdata, exp_line); end
        dfp_read = 1'b0;
        tick;
        vectors++; if (dfp_resp !== 1'b0) begin errors++; $display("FAIL rd_resp_pulse: got %b want 0", dfp_resp); end
        last_line = exp_line;
    endtask

    task automatic test_reset_midburst;
        int resp_cnt = 0;
        dfp_addr = 32'h0000_0500; dfp_read = 1'b1;
        tick;
        bmem_ready = 1'b1;
        tick;
        bmem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0500;
            bmem_rdata = 64'hAAAA_0000_0000_0000 + 64'(i);
            tick;
        end
        rst = 1'b1; dfp_read = 1'b0; bmem_rdata = 64'hAAAA_0000_0000_0002;
        tick;
        rst = 1'b0;
        vectors++; if (dfp_resp !== 1'b0) begin errors++; $display("FAIL rst_mid_resp: got %b want 0", dfp_resp); end
        vectors++; if (dfp_rdata !== 256'h0) begin errors++; $display("FAIL rst_mid_rdata: got %h want 0", dfp_rdata); end
        vectors++; if (bmem_read !== 1'b0) begin errors++; $display("FAIL rst_mid_bmem_read: got %b want 0", bmem_read); end
        vectors++; if (bmem_write !== 1'b0) begin errors++; $display("FAIL rst_mid_bmem_write: got %b want 0", bmem_write); end
        vectors++; if (bmem_addr !== 32'h0) begin errors++; $display("FAIL rst_mid_bmem_addr: got %h want 0", bmem_addr); end
        vectors++; if (bmem_wdata !== 64'h0) begin errors++; $display("FAIL rst_mid_bmem_wdata: got %h want 0", bmem_wdata); end
        bmem_rdata = 64'hAAAA_0000_0000_0003;
        tick;
        if (dfp_resp) resp_cnt++;
        bmem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (dfp_resp) resp_cnt++;
        end
        vectors++; if (resp_cnt !== 0) begin errors++; $display("FAIL rst_mid_stray_resp: got %0d want 0", resp_cnt); end
        vectors++; if (bmem_read !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: bmem_read got %b want 0", bmem_read); end
        last_line = 256'h0;
    endtask

    task automatic test_write_stall;
        int k = 0, accepted = 0, resp_cnt = 0, addr_bad = 0;
        logic [255:0] line = {64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978,
                              64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF};
        logic [255:0] sh;
        dfp_addr = 32'h8000_0040; dfp_write = 1'b1; dfp_wdata = line; bmem_ready = 1'b0;
        tick;
        for (int c = 0; c < 12; c++) begin
            if (bmem_write) begin
                k++;
                bmem_ready = (k == 2 || k == 3) ? 1'b0 : 1'b1;
                if (bmem_addr !== 32'h8000_0040) addr_bad++;
                if (bmem_ready) begin
                    sh = line >> (64 * accepted);
                    vectors++;
                    if (bmem_wdata !== sh[63:0]) begin
                        errors++; $display("FAIL wr_beat%0d: got %h want %h", accepted, bmem_wdata, sh[63:0]);
                    end
                    accepted++;
                end
            end else begin
                bmem_ready = 1'b0;
            end
            if (dfp_resp) begin
                resp_cnt++;
                vectors++;
                if (dfp_rdata !== last_line) begin errors++; $display("FAIL wr_rdata_hold: got %h want %h", dfp_rdata, last_line); end
                dfp_write = 1'b0;
            end
            tick;
        end
        bmem_ready = 1'b0; dfp_write = 1'b0;
        vectors++; if (accepted !== 4) begin errors++; $display("FAIL wr_beats: got %0d want 4", accepted); end
        vectors++; if (resp_cnt !== 1) begin errors++; $display("FAIL wr_resp_cnt: got %0d want 1", resp_cnt); end
        vectors++; if (addr_bad !== 0) begin errors++; $display("FAIL wr_addr: got %0d bad cycles want 0", addr_bad); end
    endtask

    task automatic test_stale_beat;
        logic [31:0] ra [5] = '{32'h200, 32'h100, 32'h200, 32'h200, 32'h200};
        logic [63:0] rd [5] = '{64'hA0A0_A0A0_A0A0_A0A0, 64'h5555_5555_5555_5555,
                                64'hA1A1_A1A1_A1A1_A1A1, 64'hA2A2_A2A2_A2A2_A2A2,
                                64'hA3A3_A3A3_A3A3_A3A3};
        logic [255:0] exp_line = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                                  64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
        dfp_addr = 32'h0000_0200; dfp_read = 1'b1;
        tick;
        bmem_ready = 1'b1;
        tick;
        bmem_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            bmem_rvalid = 1'b1; bmem_raddr = ra[j]; bmem_rdata = rd[j];
            tick;
            if (j == 3) begin
                vectors++; if (dfp_resp !== 1'b0) begin errors++; $display("FAIL stale_early_resp: got %b want 0", dfp_resp); end
            end
        end
        bmem_rvalid = 1'b0;
        vectors++; if (dfp_resp !== 1'b1) begin errors++; $display("FAIL stale_resp: got %b want 1", dfp_resp); end
        vectors++; if (dfp_rdata !== exp_line) begin errors++; $display("FAIL stale_line: got %h want %h", dfp_rdata, exp_line); end
        dfp_read = 1'b0;
        tick;
        last_line = exp_line;
    endtask

    task automatic test_back_to_back;
        int c = 0;
        logic [255:0] exp_line = {64'h0000_3000_0000_0003, 64'h0000_3000_0000_0002,
                                  64'h0000_3000_0000_0001, 64'h0000_3000_0000_0000};
        dfp_addr = 32'h0000_0040; dfp_write = 1'b1; dfp_wdata = {4{64'h0BAD_F00D_1234_5678}};
        bmem_ready = 1'b1;
        tick;
        while (!dfp_resp && c < 10) begin tick; c++; end
        vectors++; if (dfp_resp !== 1'b1) begin errors++; $display("FAIL b2b_wr_timeout: resp got %b want 1", dfp_resp); end
        dfp_write = 1'b0; dfp_read = 1'b1; dfp_addr = 32'h0000_3000;
        tick;
        vectors++; if (bmem_read !== 1'b0) begin errors++; $display("FAIL b2b_idle: bmem_read got %b want 0", bmem_read); end
        tick;
        vectors++; if (bmem_read !== 1'b1) begin errors++; $display("FAIL b2b_rd_req: bmem_read got %b want 1", bmem_read); end
        vectors++; if (bmem_addr !== 32'h0000_3000) begin errors++; $display("FAIL b2b_rd_addr: got %h want 00003000", bmem_addr); end
        tick;
        bmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_3000; bmem_rdata = {32'h0000_3000, 32'(i)};
            tick;
        end
        bmem_rvalid = 1'b0;
        vectors++; if (dfp_resp !== 1'b1) begin errors++; $display("FAIL b2b_rd_resp: got %b want 1", dfp_resp); end
        vectors++; if (dfp_rdata !== exp_line) begin errors++; $display("FAIL b2b_rd_line: got %h want %h", dfp_rdata, exp_line); end
        dfp_read = 1'b0;
        tick;
        last_line = exp_line;
    endtask

    task automatic test_both_requests;
        int rd_seen = 0, accepted = 0, resp_cnt = 0;
        logic [255:0] line = {64'h4040_4040_0000_0004, 64'h3030_3030_0000_0003,
                              64'h2020_2020_0000_0002, 64'h1010_1010_0000_0001};
        logic [255:0] sh;
        dfp_addr = 32'h0000_0600; dfp_read = 1'b1; dfp_write = 1'b1; dfp_wdata = line;
        bmem_ready = 1'b1;
        tick;
        for (int c = 0; c < 10; c++) begin
            if (bmem_read) rd_seen++;
            if (bmem_write && bmem_ready) begin
                sh = line >> (64 * accepted);
                vectors++;
                if (bmem_wdata !== sh[63:0]) begin
                    errors++; $display("FAIL both_beat%0d: got %h want %h", accepted, bmem_wdata, sh[63:0]);
                end
                accepted++;
            end
            if (dfp_resp) begin resp_cnt++; dfp_read = 1'b0; dfp_write = 1'b0; end
            tick;
        end
        bmem_ready = 1'b0;
        vectors++; if (rd_seen !== 0) begin errors++; $display("FAIL both_no_read: got %0d want 0", rd_seen); end
        vectors++; if (accepted !== 4) begin errors++; $display("FAIL both_beats: got %0d want 4", accepted); end
        vectors++; if (resp_cnt !== 1) begin errors++; $display("FAIL both_resp_cnt: got %0d want 1", resp_cnt); end
    endtask

`ifdef CACHELINE_ADAPTER_PERF_EN
    task automatic test_perf;
        vectors++; if (dut.rd_lines !== 64'd2) begin errors++; $display("FAIL perf_rd: got %0d want 2", dut.rd_lines); end
        vectors++; if (dut.wr_lines !== 64'd3) begin errors++; $display("FAIL perf_wr: got %0d want 3", dut.wr_lines); end
        vectors++; if (dut.stall_cycles !== 64'd2) begin errors++; $display("FAIL perf_stall: got %0d want 2", dut.stall_cycles); end
    endtask
`endif

    initial begin
        test_reset;
        test_read_basic;
        test_reset_midburst;
        test_write_stall;
        test_stale_beat;
        test_back_to_back;
        test_both_requests;
`ifdef CACHELINE_ADAPTER_PERF_EN
        test_perf;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
